// File: rtl/serial_mult_ctrl_if.sv
// rtl/serial_mult_ctrl_if.sv - start/done handshake and operand/product bundle for serial_mult_ctrl
interface serial_mult_ctrl_if #(
   parameter int WIDTH = 4
);
   logic                 start;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   p;

   // requester side: issues operands and start, observes progress and result
   modport master (
      output start,
      output a,
      output b,
      input  busy,
      input  done,
      input  p
   );

   // multiplier side
   modport slave (
      input  start,
      input  a,
      input  b,
      output busy,
      output done,
      output p
   );
endinterface

// File: rtl/serial_mult_ctrl.sv
// rtl/serial_mult_ctrl.sv - shift-add serial multiplier with start/done handshake (option: SERIAL_MULT_EARLY_TERM_EN)
module serial_mult_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   serial_mult_ctrl_if.slave  bus
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [2*WIDTH-1:0]   acc;
   logic [2*WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0]   acc_sum;
   logic [2*WIDTH-1:0]   p_q;
   logic [WIDTH-1:0]     mplier;
   logic [WIDTH-1:0]     mplier_shift;
   logic [CW-1:0]        cnt;
   logic                 accept;
   logic                 step;
   logic                 last_step;

   // state register; reset aborts any multiply in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // next-state decode plus the per-step add/shift values
   always_comb begin
      state_next   = state;
      accept       = 1'b0;
      step         = 1'b0;
      last_step    = 1'b0;
      acc_sum      = mplier[0] ? (acc + mcand) : acc;
      mplier_shift = mplier >> 1;
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept     = 1'b1;
               state_next = RUN;
`ifdef SERIAL_MULT_EARLY_TERM_EN
               // nothing to accumulate, so skip RUN entirely
               if (bus.b == '0) begin
                  state_next = DONE;
               end
`endif
            end
         end
         RUN: begin
            step = 1'b1;
`ifdef SERIAL_MULT_EARLY_TERM_EN
            // stop once no set multiplier bits remain; cnt bound is a backstop
            last_step = (cnt == CW'(WIDTH - 1)) || (mplier_shift == '0);
`else
            last_step = (cnt == CW'(WIDTH - 1));
`endif
            if (last_step) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (bus.start) begin
               accept     = 1'b1;
               state_next = RUN;
`ifdef SERIAL_MULT_EARLY_TERM_EN
               if (bus.b == '0) begin
                  state_next = DONE;
               end
`endif
            end else begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // datapath: latch operands on accept, one shift-add per RUN cycle, capture product on exit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
         p_q    <= '0;
      end else if (accept) begin
         acc    <= '0;
         mcand  <= {{WIDTH{1'b0}}, bus.a};
         mplier <= bus.b;
         cnt    <= '0;
`ifdef SERIAL_MULT_EARLY_TERM_EN
         if (bus.b == '0) begin
            p_q <= '0;
         end
`endif
      end else if (step) begin
         acc    <= acc_sum;
         mcand  <= mcand << 1;
         mplier <= mplier_shift;
         cnt    <= cnt + CW'(1);
         if (last_step) begin
            p_q <= acc_sum;
         end
      end
   end

   assign bus.busy = (state == RUN);
   assign bus.done = (state == DONE);
   assign bus.p    = p_q;

endmodule

// File: tb/tb_serial_mult_ctrl.sv
// tb/tb_serial_mult_ctrl.sv - directed self-checking bench for serial_mult_ctrl (WIDTH=4)
module tb_serial_mult_ctrl;
   localparam int WIDTH = 4;

`ifdef SERIAL_MULT_EARLY_TERM_EN
   localparam int LAT_B0  = 1;
   localparam int LAT_B3  = 3;
   localparam int LAT_B67 = 4;
   localparam int LAT_B5  = 4;
`else
   localparam int LAT_B0  = 5;
   localparam int LAT_B3  = 5;
   localparam int LAT_B67 = 5;
   localparam int LAT_B5  = 5;
`endif
   localparam int LAT_B9F = 5;

   logic clk;
   logic rst_n;
   int   n_assert;
   int   n_fail;

   serial_mult_ctrl_if #(.WIDTH(WIDTH)) bus ();

   serial_mult_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // called just after the negedge that follows the accept edge; lat counts that cycle as 1
   task automatic wait_done(output int lat);
      lat = 1;
      while (bus.done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_op(input logic [3:0] av, input logic [3:0] bv, output int lat);
      bus.start = 1'b1;
      bus.a     = av;
      bus.b     = bv;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(lat);
   endtask

   initial begin
      int  lat;
      int  el;
      logic seen_done;
      logic [3:0] av;
      logic [3:0] bv;
      n_assert  = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (2) @(negedge clk);
      chk("reset_busy", 32'(bus.busy), 0);
      chk("reset_done", 32'(bus.done), 0);
      chk("reset_p", 32'(bus.p), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_busy", 32'(bus.busy), 0);

      // 1: all-ones operands, cycle-by-cycle busy/done
      bus.start = 1'b1;
      bus.a     = 4'd15;
      bus.b     = 4'd15;
      @(negedge clk);
      bus.start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         chk("t1_busy", 32'(bus.busy), 1);
         chk("t1_done_low", 32'(bus.done), 0);
         @(negedge clk);
      end
      chk("t1_done", 32'(bus.done), 1);
      chk("t1_busy_low", 32'(bus.busy), 0);
      chk("t1_p", 32'(bus.p), 225);
      @(negedge clk);
      chk("t1_done_pulse", 32'(bus.done), 0);

      // 2: zero operands
      run_op(4'd0, 4'd9, lat);
      chk("t2_lat_a0", 32'(lat), LAT_B9F);
      chk("t2_p_a0", 32'(bus.p), 0);
      @(negedge clk);
      run_op(4'd15, 4'd15, lat);
      chk("t2_p_nonzero", 32'(bus.p), 225);
      @(negedge clk);
      run_op(4'd9, 4'd0, lat);
      chk("t2_lat_b0", 32'(lat), LAT_B0);
      chk("t2_p_b0", 32'(bus.p), 0);
      @(negedge clk);

      // 3: back-to-back accept during DONE
      run_op(4'd3, 4'd5, lat);
      chk("t3_lat1", 32'(lat), LAT_B5);
      chk("t3_p1", 32'(bus.p), 15);
      bus.start = 1'b1;
      bus.a     = 4'd7;
      bus.b     = 4'd6;
      @(negedge clk);
      bus.start = 1'b0;
      chk("t3_no_gap", 32'(bus.busy), 1);
      chk("t3_p_hold", 32'(bus.p), 15);
      wait_done(lat);
      chk("t3_lat2", 32'(lat), LAT_B67);
      chk("t3_p2", 32'(bus.p), 42);
      @(negedge clk);

      // 4: start and operand churn during RUN are ignored
      bus.start = 1'b1;
      bus.a     = 4'd6;
      bus.b     = 4'd7;
      @(negedge clk);
      lat = 1;
      while (bus.done !== 1'b1 && lat < 40) begin
         bus.start = (lat <= 2);
         bus.a     = 4'($urandom);
         bus.b     = 4'($urandom);
         @(negedge clk);
         lat++;
      end
      bus.start = 1'b0;
      chk("t4_lat", 32'(lat), LAT_B67);
      chk("t4_p", 32'(bus.p), 42);
      @(negedge clk);
      chk("t4_single_result", 32'(bus.done), 0);

      // 5: asynchronous reset mid-RUN
      bus.start = 1'b1;
      bus.a     = 4'd5;
      bus.b     = 4'd5;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      chk("t5_busy_before", 32'(bus.busy), 1);
      rst_n = 1'b0;
      #1;
      chk("t5_busy_rst", 32'(bus.busy), 0);
      chk("t5_done_rst", 32'(bus.done), 0);
      chk("t5_p_rst", 32'(bus.p), 0);
      #3;
      rst_n = 1'b1;
      seen_done = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         seen_done = seen_done | bus.done | bus.busy;
      end
      chk("t5_no_done_after_abort", 32'(seen_done), 0);
      run_op(4'd2, 4'd3, lat);
      chk("t5_lat", 32'(lat), LAT_B3);
      chk("t5_p", 32'(bus.p), 6);

      // 6: exhaustive, back-to-back
      for (int i = 0; i < 256; i++) begin
         av = 4'(i >> 4);
         bv = 4'(i);
`ifdef SERIAL_MULT_EARLY_TERM_EN
         el = 1;
         for (int k = 0; k < 4; k++) begin
            if (bv[k]) el = k + 2;
         end
`else
         el = 5;
`endif
         run_op(av, bv, lat);
         chk("t6_p", 32'(bus.p), 32'(int'(av) * int'(bv)));
         chk("t6_lat", 32'(lat), 32'(el));
      end
      @(negedge clk);
      chk("t6_idle", 32'(bus.busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
